// File: rtl/weight_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : weight_mem_scheduler
// Brief    : Shares one LSTM weight BRAM between the off-line weight loader
//            (writes) and a gate MAC (row-major matrix streaming reads).
//            Issues read addresses, tracks the two-stage registered read
//            pipeline under consumer backpressure and tags each word with
//            end-of-row / end-of-pass markers.
// Revision : 1.0 - initial release
// ============================================================================
module weight_mem_scheduler #(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 400,
    parameter int RAM_ADDR  = 9,
    parameter int ROWS      = 20,
    parameter int COLS      = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [RAM_ADDR-1:0]  base_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 load_req,
    input  logic [RAM_ADDR-1:0]  load_addr,
    input  logic [RAM_WIDTH-1:0] load_data,
    output logic                 load_ack,
    output logic                 mem_ce0,
    output logic [RAM_ADDR-1:0]  mem_addr0,
    output logic                 mem_ce1,
    output logic                 mem_we1,
    output logic [RAM_ADDR-1:0]  mem_addr1,
    output logic [RAM_WIDTH-1:0] mem_win,
    output logic                 mem_reset_n,
    input  logic [RAM_WIDTH-1:0] mem_rdata,
    output logic                 out_valid,
    output logic [RAM_WIDTH-1:0] out_data,
    output logic                 out_last_col,
    output logic                 out_last_row,
    input  logic                 out_ready
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam int c_row_w = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_col_w = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [c_row_w-1:0]  c_last_row = c_row_w'(ROWS - 1);
    localparam logic [c_col_w-1:0]  c_last_col = c_col_w'(COLS - 1);
    localparam logic [c_row_w-1:0]  c_row_one  = c_row_w'(1);
    localparam logic [c_col_w-1:0]  c_col_one  = c_col_w'(1);
    localparam logic [RAM_ADDR-1:0] c_addr_one = RAM_ADDR'(1);
    localparam logic [31:0]         c_depth    = 32'(RAM_DEPTH);
    localparam logic [31:0]         c_pass_len = 32'(ROWS * COLS);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [RAM_ADDR-1:0] r_addr;
    logic [c_row_w-1:0]  r_row;
    logic [c_col_w-1:0]  r_col;
    // Read-pipeline tags, {valid, last_col, last_row}; r_t1 tracks the BRAM
    // address stage, r_t2 tracks the BRAM output register.
    logic [2:0]          r_t1;
    logic [2:0]          r_t2;
    logic                r_err;

    logic w_idle;
    logic w_advance;
    logic w_issue;
    logic w_last_col;
    logic w_last_row;
    logic w_load_ok;
    logic w_start_fits;
    logic w_start_ok;

    assign w_idle       = (r_state == c_st_idle);
    // The pipeline may move whenever the output slot is empty or being taken.
    assign w_advance    = ~r_t2[2] | out_ready;
    assign w_issue      = (r_state == c_st_read) & w_advance;
    assign w_last_col   = (r_col == c_last_col);
    assign w_last_row   = (r_row == c_last_row) & w_last_col;
    assign w_load_ok    = (32'(load_addr) < c_depth);
    assign w_start_fits = ((32'(base_addr) + c_pass_len) <= c_depth);
    // A load request in the same cycle always wins over start.
    assign w_start_ok   = w_idle & start & ~load_req & w_start_fits;

    assign mem_addr0    = r_addr;
    assign mem_addr1    = load_addr;
    assign mem_win      = load_data;
    assign mem_reset_n  = ~reset;
    assign out_data     = mem_rdata;
    assign out_valid    = r_t2[2];
    assign out_last_col = r_t2[1];
    assign out_last_row = r_t2[0];
    assign err          = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_start_ok) begin
                    w_state_nxt = c_st_read;
                end
            end
            c_st_read: begin
                if (w_issue && w_last_row) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                // Leave once the pipeline will be empty after this edge.
                if (!r_t1[2] && w_advance) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Output decode: status, write-port arbitration and read enable
    always_comb begin
        busy     = ~w_idle;
        done     = (r_state == c_st_done);
        // The BRAM forces addr1 to zero under reset, so no write may go out then.
        load_ack = w_idle & load_req & ~reset;
        mem_ce1  = load_ack & w_load_ok;
        mem_we1  = load_ack & w_load_ok;
        // Dropping ce0 freezes both BRAM stages, which is the backpressure path.
        mem_ce0  = w_advance & ((r_state == c_st_read) | r_t1[2] | r_t2[2]);
    end

    // Address incrementer, row/column counters, tag pipeline and error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_t1   <= '0;
            r_t2   <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_addr <= base_addr;
                r_row  <= '0;
                r_col  <= '0;
            end else if (w_issue) begin
                r_addr <= r_addr + c_addr_one;
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : (r_row + c_row_one);
                end else begin
                    r_col <= r_col + c_col_one;
                end
            end
            if (w_advance) begin
                r_t1 <= {w_issue, w_issue & w_last_col, w_issue & w_last_row};
                r_t2 <= r_t1;
            end
            r_err <= (w_idle & load_req & ~w_load_ok)
                   | (w_idle & start & ~load_req & ~w_start_fits);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_weight_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_mem_scheduler
// Brief    : Self-checking bench for weight_mem_scheduler with a behavioural
//            two-stage BRAM and a scoreboard of expected weight words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_mem_scheduler;

    localparam int W = 16;
    localparam int D = 400;
    localparam int A = 9;
    localparam int R = 20;
    localparam int C = 20;
    localparam int N = R * C;

    logic         clk;
    logic         reset;
    logic         start;
    logic [A-1:0] base_addr;
    logic         busy;
    logic         done;
    logic         err;
    logic         load_req;
    logic [A-1:0] load_addr;
    logic [W-1:0] load_data;
    logic         load_ack;
    logic         mem_ce0;
    logic [A-1:0] mem_addr0;
    logic         mem_ce1;
    logic         mem_we1;
    logic [A-1:0] mem_addr1;
    logic [W-1:0] mem_win;
    logic         mem_reset_n;
    logic [W-1:0] mem_rdata;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last_col;
    logic         out_last_row;
    logic         out_ready;

    weight_mem_scheduler #(
        .RAM_WIDTH(W), .RAM_DEPTH(D), .RAM_ADDR(A), .ROWS(R), .COLS(C)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .err(err),
        .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
        .load_ack(load_ack),
        .mem_ce0(mem_ce0), .mem_addr0(mem_addr0),
        .mem_ce1(mem_ce1), .mem_we1(mem_we1), .mem_addr1(mem_addr1),
        .mem_win(mem_win), .mem_reset_n(mem_reset_n), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data),
        .out_last_col(out_last_col), .out_last_row(out_last_row),
        .out_ready(out_ready)
    );

    // Behavioural BRAM: single write port, two registered read stages frozen by ce0=0
    logic [W-1:0] bram [0:D-1];
    logic [W-1:0] bram_s1;
    logic [W-1:0] bram_s2;
    always @(posedge clk) begin
        if (mem_ce1 && mem_we1 && (int'(mem_addr1) < D)) bram[mem_addr1] <= mem_win;
        if (!mem_reset_n) begin
            bram_s1 <= '0;
            bram_s2 <= '0;
        end else if (mem_ce0) begin
            bram_s1 <= (int'(mem_addr0) < D) ? bram[mem_addr0] : '0;
            bram_s2 <= bram_s1;
        end
    end
    assign mem_rdata = bram_s2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [W-1:0]  model_mem [0:D-1];
    logic [W+1:0]  sb_q [$];
    int first_valid_cyc, last_row_cyc, done_cyc, done_cnt;
    int acc_cnt, lastcol_cnt, lastrow_cnt;
    bit prev_stall = 1'b0;
    logic [W+1:0] held_word;

    // Output monitor: pops the scoreboard on every accepted word (sampled on negedge)
    task automatic monitor();
        logic [W+1:0] got;
        logic [W+1:0] exp;
        forever begin
            @(negedge clk);
            got = {out_data, out_last_col, out_last_row};
            if (reset) begin
                checks++;
                if (mem_ce1 !== 1'b0) begin
                    errors++;
                    $display("FAIL ce1_in_reset: mem_ce1=%b required 0", mem_ce1);
                end
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (out_valid !== 1'b1 || got !== held_word) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%b word=%h required valid=1 word=%h",
                                 out_valid, got, held_word);
                    end
                end
                if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_word: data=%h with empty scoreboard", out_data);
                    end else begin
                        exp = sb_q.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL word%0d: data=%h lc=%b lr=%b required data=%h lc=%b lr=%b",
                                     acc_cnt, got[W+1:2], got[1], got[0], exp[W+1:2], exp[1], exp[0]);
                        end
                    end
                    acc_cnt++;
                    if (out_last_col === 1'b1) lastcol_cnt++;
                    if (out_last_row === 1'b1) begin
                        lastrow_cnt++;
                        last_row_cyc = cyc;
                    end
                end
                prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
                held_word  = got;
                if (done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                    checks++;
                    if (sb_q.size() != 0) begin
                        errors++;
                        $display("FAIL done_early: %0d words outstanding required 0", sb_q.size());
                    end
                end
                if (mem_ce1 === 1'b1 && mem_we1 === 1'b1) begin
                    checks++;
                    if (int'(mem_addr1) >= D) begin
                        errors++;
                        $display("FAIL write_range: addr1=%0d required < %0d", mem_addr1, D);
                    end
                end
            end
        end
    endtask

    // One full pass starting in the current cycle T; optional random ready,
    // timing checks and a loader request held through the pass.
    task automatic run_pass(input int base, input bit rand_ready, input bit timing_chk,
                            input bit hold_load);
        int t0;
        int guard;
        for (int i = 0; i < N; i++)
            sb_q.push_back({model_mem[base + i], (i % C) == (C - 1), i == (N - 1)});
        first_valid_cyc = -1; last_row_cyc = -1; done_cyc = -1; done_cnt = 0;
        acc_cnt = 0; lastcol_cnt = 0; lastrow_cnt = 0;
        start = 1'b1; base_addr = A'(base); load_req = 1'b0; out_ready = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || mem_ce0 !== 1'b1 || mem_addr0 !== A'(base)) begin
            errors++;
            $display("FAIL first_issue: busy=%b ce0=%b addr0=%0d required 1 1 %0d",
                     busy, mem_ce0, mem_addr0, base);
        end
        start = 1'b0;
        if (hold_load) begin
            load_req = 1'b1; load_addr = A'(7); load_data = 16'h1234;
        end
        guard = 0;
        while (busy === 1'b1 && guard < 5000) begin
            if (hold_load) begin
                #1;
                checks++;
                if (load_ack !== 1'b0 || mem_ce1 !== 1'b0) begin
                    errors++;
                    $display("FAIL load_held_off: ack=%b ce1=%b required 0 0", load_ack, mem_ce1);
                end
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 5000) begin
            checks++; errors++;
            $display("FAIL pass_timeout: busy still %b after %0d cycles", busy, guard);
        end
        checks++;
        if (done_cnt != 1 || sb_q.size() != 0 || acc_cnt != N || lastcol_cnt != R || lastrow_cnt != 1) begin
            errors++;
            $display("FAIL pass_summary: done=%0d left=%0d words=%0d lastcol=%0d lastrow=%0d required 1 0 %0d %0d 1",
                     done_cnt, sb_q.size(), acc_cnt, lastcol_cnt, lastrow_cnt, N, R);
        end
        if (timing_chk) begin
            checks++;
            if (first_valid_cyc != t0 + 3) begin
                errors++;
                $display("FAIL first_valid: cycle T+%0d required T+3", first_valid_cyc - t0);
            end
            checks++;
            if (last_row_cyc != t0 + N + 2) begin
                errors++;
                $display("FAIL last_word: cycle T+%0d required T+%0d", last_row_cyc - t0, N + 2);
            end
            checks++;
            if (done_cyc != t0 + N + 3) begin
                errors++;
                $display("FAIL done_time: cycle T+%0d required T+%0d", done_cyc - t0, N + 3);
            end
            checks++;
            if (cyc != t0 + N + 4) begin
                errors++;
                $display("FAIL busy_drop: cycle T+%0d required T+%0d", cyc - t0, N + 4);
            end
        end
        if (hold_load) begin
            #1;
            checks++;
            if (load_ack !== 1'b1 || mem_ce1 !== 1'b1 || mem_we1 !== 1'b1 || cyc != done_cyc + 1) begin
                errors++;
                $display("FAIL load_after_done: ack=%b ce1=%b we1=%b at done+%0d required 1 1 1 at done+1",
                         load_ack, mem_ce1, mem_we1, cyc - done_cyc);
            end
            model_mem[7] = 16'h1234;
            @(posedge clk); #1;
            load_req = 1'b0;
        end
        sb_q.delete();
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, out_valid, out_last_col, out_last_row, mem_ce0, mem_reset_n} !== 8'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b err=%b valid=%b lc=%b lr=%b ce0=%b rst_n=%b required all 0",
                     busy, done, err, out_valid, out_last_col, out_last_row, mem_ce0, mem_reset_n);
        end
        load_req = 1'b1; load_addr = A'(3); load_data = 16'h5555;
        #1;
        checks++;
        if (mem_ce1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_write: mem_ce1=%b required 0", mem_ce1);
        end
        @(posedge clk); #1;
        reset = 1'b0; load_req = 1'b0;
        #1;
        checks++;
        if (mem_reset_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rst_n=%b busy=%b required 1 0", mem_reset_n, busy);
        end
    endtask

    task automatic test_load_all();
        for (int a = 0; a < D; a++) begin
            load_req = 1'b1; load_addr = A'(a); load_data = W'(a);
            #1;
            checks++;
            if (load_ack !== 1'b1 || mem_ce1 !== 1'b1 || mem_we1 !== 1'b1 || mem_addr1 !== A'(a)) begin
                errors++;
                $display("FAIL load%0d: ack=%b ce1=%b we1=%b addr1=%0d required 1 1 1 %0d",
                         a, load_ack, mem_ce1, mem_we1, mem_addr1, a);
            end
            model_mem[a] = W'(a);
            @(posedge clk); #1;
        end
        load_req = 1'b0;
    endtask

    task automatic test_full_speed();
        run_pass(0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_pass(0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_start_with_load();
        start = 1'b1; base_addr = '0;
        load_req = 1'b1; load_addr = A'(5); load_data = 16'hABCD;
        #1;
        checks++;
        if (load_ack !== 1'b1 || mem_ce1 !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_vs_load: ack=%b ce1=%b busy=%b required 1 1 0", load_ack, mem_ce1, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL start_deferred: busy=%b err=%b required 0 0", busy, err);
        end
        model_mem[5] = 16'hABCD;
        load_req = 1'b0;
        run_pass(0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_bad_start();
        start = 1'b1; base_addr = A'(1); load_req = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || mem_ce0 !== 1'b0) begin
            errors++;
            $display("FAIL bad_start: err=%b busy=%b ce0=%b required 1 0 0", err, busy, mem_ce0);
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || mem_ce0 !== 1'b0) begin
            errors++;
            $display("FAIL bad_start_after: err=%b busy=%b ce0=%b required 0 0 0", err, busy, mem_ce0);
        end
    endtask

    task automatic test_bad_load();
        load_req = 1'b1; load_addr = A'(400); load_data = 16'hFFFF;
        #1;
        checks++;
        if (load_ack !== 1'b1 || mem_we1 !== 1'b0 || mem_ce1 !== 1'b0) begin
            errors++;
            $display("FAIL bad_load: ack=%b we1=%b ce1=%b required 1 0 0", load_ack, mem_we1, mem_ce1);
        end
        @(posedge clk); #1;
        load_req = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL bad_load_err: err=%b required 1", err);
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL bad_load_err_pulse: err=%b required 0", err);
        end
    endtask

    task automatic test_reset_mid_pass();
        int guard;
        acc_cnt = 0; done_cnt = 0; first_valid_cyc = -1;
        for (int i = 0; i < N; i++)
            sb_q.push_back({model_mem[i], (i % C) == (C - 1), i == (N - 1)});
        start = 1'b1; base_addr = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (acc_cnt < 150 && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (guard >= 1000 || out_valid !== 1'b1 || out_data !== model_mem[150]) begin
            errors++;
            $display("FAIL word150: valid=%b data=%h after %0d cycles required 1 %h",
                     out_valid, out_data, guard, model_mem[150]);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || mem_ce0 !== 1'b0 || done !== 1'b0
            || out_last_col !== 1'b0 || out_last_row !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b ce0=%b done=%b lc=%b lr=%b required all 0",
                     out_valid, busy, mem_ce0, done, out_last_col, out_last_row);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL mid_reset_done: done pulses=%0d required 0", done_cnt);
        end
        run_pass(0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_load_during_pass();
        run_pass(0, 1'b0, 1'b1, 1'b1);
        run_pass(0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0;
        load_req = 1'b0; load_addr = '0; load_data = '0; out_ready = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_load_all();
        test_full_speed();
        test_backpressure();
        test_start_with_load();
        test_bad_start();
        test_bad_load();
        test_reset_mid_pass();
        test_load_during_pass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
